// File: rtl/fetch_stage.sv
// Instruction fetch + IF/ID register: zero-wait memory gives 1 instr/cycle, IF/ID updates one edge after response.
// Backpressure: stall freezes pc and IF/ID, a response landing during stall parks in a one-entry skid register.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] IF_ID_PC,
    output logic [31:0] IF_ID_Inst,
    output logic        IF_ID_valid,
    output logic [4:0]  IF_ID_RegRs1,
    output logic [4:0]  IF_ID_RegRs2
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc_nxt;
    logic [31:0] pc_inc;
    logic [31:0] skid_inst;
    logic [31:0] skid_nxt;
    logic [31:0] ifid_pc_nxt;
    logic [31:0] ifid_inst_nxt;
    logic        ifid_valid_nxt;

    assign pc_inc = pc + 32'd4;

    // Request depends only on registered state so the response never loops back into it.
    assign imem_req  = !rst && (state == FETCH);
    assign imem_addr = pc;

    assign IF_ID_RegRs1 = IF_ID_Inst[19:15];
    assign IF_ID_RegRs2 = IF_ID_Inst[24:20];

    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        skid_nxt       = skid_inst;
        ifid_pc_nxt    = IF_ID_PC;
        ifid_inst_nxt  = IF_ID_Inst;
        ifid_valid_nxt = IF_ID_valid;

        if (branch_taken) begin
            ifid_inst_nxt  = NOP_INST;
            ifid_valid_nxt = 1'b0;
            pc_nxt         = {branch_target[31:2], 2'b00};
            skid_nxt       = NOP_INST;
            // A request still owed by memory must be swallowed before refetching.
            if ((state == FETCH || state == DRAIN) && !imem_rvalid) begin
                state_nxt = DRAIN;
            end else begin
                state_nxt = FETCH;
            end
        end else begin
            case (state)
                FETCH: begin
                    if (stall) begin
                        if (imem_rvalid) begin
                            skid_nxt  = imem_rdata;
                            state_nxt = HOLD;
                        end
                    end else if (imem_rvalid) begin
                        ifid_inst_nxt  = imem_rdata;
                        ifid_pc_nxt    = pc;
                        ifid_valid_nxt = 1'b1;
                        pc_nxt         = pc_inc;
                    end else begin
                        ifid_inst_nxt  = NOP_INST;
                        ifid_valid_nxt = 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        ifid_inst_nxt  = skid_inst;
                        ifid_pc_nxt    = pc;
                        ifid_valid_nxt = 1'b1;
                        pc_nxt         = pc_inc;
                        state_nxt      = FETCH;
                    end
                end
                DRAIN: begin
                    if (!stall) begin
                        ifid_inst_nxt  = NOP_INST;
                        ifid_valid_nxt = 1'b0;
                    end
                    if (imem_rvalid) begin
                        state_nxt = FETCH;
                    end
                end
                default: begin
                    state_nxt = FETCH;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            skid_inst   <= NOP_INST;
            IF_ID_PC    <= 32'h0000_0000;
            IF_ID_Inst  <= NOP_INST;
            IF_ID_valid <= 1'b0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            skid_inst   <= skid_nxt;
            IF_ID_PC    <= ifid_pc_nxt;
            IF_ID_Inst  <= ifid_inst_nxt;
            IF_ID_valid <= ifid_valid_nxt;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a latency-programmable memory, a transaction-level model and a per-cycle compare.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] IF_ID_PC;
    logic [31:0] IF_ID_Inst;
    logic        IF_ID_valid;
    logic [4:0]  IF_ID_RegRs1;
    logic [4:0]  IF_ID_RegRs2;

    fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INST(NOP)) dut (
        .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
        .branch_target(branch_target), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .pc(pc),
        .IF_ID_PC(IF_ID_PC), .IF_ID_Inst(IF_ID_Inst), .IF_ID_valid(IF_ID_valid),
        .IF_ID_RegRs1(IF_ID_RegRs1), .IF_ID_RegRs2(IF_ID_RegRs2)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // Memory environment: one outstanding request, answered after `lat` wait cycles.
    int          lat = 0;
    bit          mem_busy = 1'b0;
    int          mem_cnt = 0;
    logic [31:0] mem_addr_q = 32'h0;

    // Expected fetch-stage view: what the pipeline must show, in transaction terms.
    logic [31:0] m_pc, m_ifpc, m_inst;
    logic        m_valid;
    bit          m_drop;
    logic [31:0] parked[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h0000_0008) ? 32'h00A0_0093 : a;
    endfunction

    function automatic logic exp_req();
        return !rst && !m_drop && (parked.size() == 0);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bubble();
        m_inst  = NOP;
        m_valid = 1'b0;
    endtask

    task automatic deliver(input logic [31:0] w);
        m_inst  = w;
        m_ifpc  = m_pc;
        m_valid = 1'b1;
        m_pc    = m_pc + 32'd4;
    endtask

    task automatic mem_drive();
        imem_rvalid = 1'b0;
        imem_rdata  = 32'hDEAD_BEEF;
        if (!rst) begin
            if (!mem_busy && imem_req) begin
                mem_busy   = 1'b1;
                mem_addr_q = imem_addr;
                mem_cnt    = lat;
            end
            if (mem_busy && mem_cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(mem_addr_q);
            end
        end
    endtask

    task automatic drive(input logic r, input logic st, input logic b, input logic [31:0] t);
        rst           = r;
        stall         = st;
        branch_taken  = b;
        branch_target = t;
        #1;
        mem_drive();
    endtask

    task automatic tick();
        bit fetching;
        @(posedge clk);
        fetching = !m_drop && (parked.size() == 0);
        if (rst) begin
            m_pc = 32'h0; m_ifpc = 32'h0; m_drop = 1'b0;
            parked.delete();
            bubble();
        end else if (branch_taken) begin
            m_drop = (fetching || m_drop) && !imem_rvalid;
            parked.delete();
            bubble();
            m_pc = {branch_target[31:2], 2'b00};
        end else if (m_drop) begin
            if (!stall) bubble();
            if (imem_rvalid) m_drop = 1'b0;
        end else if (parked.size() != 0) begin
            if (!stall) deliver(parked.pop_front());
        end else if (imem_rvalid) begin
            if (stall) parked.push_back(imem_rdata);
            else deliver(imem_rdata);
        end else if (!stall) begin
            bubble();
        end
        if (rst || imem_rvalid) mem_busy = 1'b0;
        else if (mem_busy && mem_cnt > 0) mem_cnt--;
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("pc", pc, m_pc);
            chk("if_id_pc", IF_ID_PC, m_ifpc);
            chk("if_id_inst", IF_ID_Inst, m_inst);
            chk("if_id_valid", 32'(IF_ID_valid), 32'(m_valid));
            chk("rs1", 32'(IF_ID_RegRs1), 32'(m_inst[19:15]));
            chk("rs2", 32'(IF_ID_RegRs2), 32'(m_inst[24:20]));
            chk("imem_req", 32'(imem_req), 32'(exp_req()));
            if (exp_req()) chk("imem_addr", imem_addr, m_pc);
            if (mem_busy && imem_req) chk("addr_hold", imem_addr, mem_addr_q);
        end
    end

    initial begin
        logic [23:0] spat;
        spat = 24'b0011_0100_0110_0010_1100_0100;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        m_pc = 32'h0; m_ifpc = 32'h0; m_inst = NOP; m_valid = 1'b0; m_drop = 1'b0;

        // Reset and zero-wait streaming
        drive(1, 0, 0, 0); tick();
        chk_en = 1'b1;
        drive(1, 0, 0, 0);
        chk("req_in_reset", 32'(imem_req), 32'h0);
        tick();
        chk("rst_inst", IF_ID_Inst, NOP);
        chk("rst_valid", 32'(IF_ID_valid), 32'h0);
        drive(0, 0, 0, 0); tick();
        chk("s1_ifpc", IF_ID_PC, 32'h0);
        chk("s1_valid", 32'(IF_ID_valid), 32'h1);
        chk("s1_pc", pc, 32'h4);
        drive(0, 0, 0, 0); tick();
        chk("s2_ifpc", IF_ID_PC, 32'h4);

        // Stall with response captured at pc=8
        drive(0, 1, 0, 0); tick();
        drive(0, 1, 0, 0);
        chk("hold_req", 32'(imem_req), 32'h0);
        tick();
        chk("hold_ifpc", IF_ID_PC, 32'h4);
        chk("hold_inst", IF_ID_Inst, 32'h4);
        drive(0, 0, 0, 0); tick();
        chk("rel_inst", IF_ID_Inst, 32'h00A0_0093);
        chk("rel_ifpc", IF_ID_PC, 32'h8);
        chk("rel_pc", pc, 32'hC);
        chk("rel_rs2", 32'(IF_ID_RegRs2), 32'd10);

        // Three-cycle memory latency
        lat = 2;
        drive(0, 0, 0, 0);
        chk("lat_addr0", imem_addr, 32'hC);
        tick();
        chk("lat_bubble_inst", IF_ID_Inst, NOP);
        chk("lat_bubble_valid", 32'(IF_ID_valid), 32'h0);
        drive(0, 0, 0, 0);
        chk("lat_addr1", imem_addr, 32'hC);
        tick();
        drive(0, 0, 0, 0);
        chk("lat_addr2", imem_addr, 32'hC);
        tick();
        chk("lat_ifpc", IF_ID_PC, 32'hC);
        chk("lat_pc", pc, 32'h10);

        // Redirect while a two-cycle fetch is outstanding
        lat = 1;
        drive(0, 0, 1, 32'h0000_0103); tick();
        chk("br_pc", pc, 32'h100);
        chk("br_inst", IF_ID_Inst, NOP);
        lat = 0;
        drive(0, 0, 0, 0);
        chk("drain_req", 32'(imem_req), 32'h0);
        tick();
        chk("drain_valid", 32'(IF_ID_valid), 32'h0);
        drive(0, 0, 0, 0);
        chk("post_drain_addr", imem_addr, 32'h100);
        tick();
        chk("post_drain_ifpc", IF_ID_PC, 32'h100);

        // Branch and stall with a same-cycle response
        drive(0, 1, 1, 32'h0000_0200); tick();
        chk("bs_pc", pc, 32'h200);
        chk("bs_valid", 32'(IF_ID_valid), 32'h0);
        drive(0, 0, 0, 0);
        chk("bs_req", 32'(imem_req), 32'h1);
        chk("bs_addr", imem_addr, 32'h200);
        tick();
        chk("bs_ifpc", IF_ID_PC, 32'h200);

        // Reset in the middle of HOLD
        drive(0, 1, 0, 0); tick();
        drive(0, 1, 0, 0); tick();
        drive(1, 1, 0, 0); tick();
        chk("hr_pc", pc, 32'h0);
        chk("hr_valid", 32'(IF_ID_valid), 32'h0);
        drive(0, 0, 0, 0);
        chk("hr_req", 32'(imem_req), 32'h1);
        chk("hr_addr", imem_addr, 32'h0);
        tick();
        chk("hr_inst", IF_ID_Inst, 32'h0);

        // PC wrap at the top of the address space
        drive(0, 0, 1, 32'hFFFF_FFFE); tick();
        chk("wrap_pc0", pc, 32'hFFFF_FFFC);
        drive(0, 0, 0, 0); tick();
        chk("wrap_ifpc", IF_ID_PC, 32'hFFFF_FFFC);
        chk("wrap_pc1", pc, 32'h0);
        chk("wrap_rs1", 32'(IF_ID_RegRs1), 32'd31);

        // Mixed latency, stall and redirect sequence checked by the model
        for (int i = 0; i < 24; i++) begin
            lat = i % 3;
            if (i == 10) drive(0, spat[i], 1, 32'h0000_0040);
            else if (i == 17) drive(0, spat[i], 1, 32'h0000_0082);
            else drive(0, spat[i], 0, 0);
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0); tick();
        end
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
